// File: rtl/ras_predictor_pkg.sv
// ras_predictor_pkg
//   Shared fetch-unit types for the return address stack: geometry
//   constants, PC / pointer / occupancy types, the per-fetch-group
//   checkpoint struct and saturating occupancy helpers.
package ras_predictor_pkg;

    localparam int FETCH_WIDTH     = 2;
    localparam int RAS_DEPTH       = 8;   // must be a power of two
    localparam int PC_WIDTH        = 32;
    localparam int INSN_BYTE_WIDTH = 4;

    localparam int RAS_ENTRY_NUM_BIT_WIDTH = $clog2(RAS_DEPTH);
    localparam int FETCH_LANE_BIT_WIDTH    = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

    typedef logic [PC_WIDTH-1:0]                PC_Path;
    typedef logic [RAS_ENTRY_NUM_BIT_WIDTH-1:0] RasPointerPath;
    typedef logic [RAS_ENTRY_NUM_BIT_WIDTH:0]   RasCountPath;
    typedef logic [FETCH_LANE_BIT_WIDTH-1:0]    FetchLaneIndexPath;

    // Pointer/occupancy snapshot carried with each fetch group for recovery.
    typedef struct packed {
        RasPointerPath ptr;
        RasCountPath   count;
    } RasCheckpoint;

    localparam RasCountPath RAS_COUNT_ZERO = {(RAS_ENTRY_NUM_BIT_WIDTH+1){1'b0}};
    localparam RasCountPath RAS_COUNT_ONE  = {{RAS_ENTRY_NUM_BIT_WIDTH{1'b0}}, 1'b1};
    localparam RasCountPath RAS_COUNT_FULL = {1'b1, {RAS_ENTRY_NUM_BIT_WIDTH{1'b0}}};
    localparam RasPointerPath RAS_PTR_ZERO = {RAS_ENTRY_NUM_BIT_WIDTH{1'b0}};
    localparam RasPointerPath RAS_PTR_ONE  = {{(RAS_ENTRY_NUM_BIT_WIDTH-1){1'b0}}, 1'b1};

    // Occupancy after a push: saturates at RAS_DEPTH (oldest entry is lost).
    function automatic RasCountPath ras_count_inc(input RasCountPath c);
        return (c >= RAS_COUNT_FULL) ? RAS_COUNT_FULL : (c + RAS_COUNT_ONE);
    endfunction

    // Occupancy after a pop: never goes below zero.
    function automatic RasCountPath ras_count_dec(input RasCountPath c);
        return (c == RAS_COUNT_ZERO) ? RAS_COUNT_ZERO : (c - RAS_COUNT_ONE);
    endfunction

    // Occupancy after a push-and-pop (replace top): at least one entry.
    function automatic RasCountPath ras_count_floor1(input RasCountPath c);
        return (c == RAS_COUNT_ZERO) ? RAS_COUNT_ONE : c;
    endfunction

endpackage

// File: rtl/ras_predictor_if.sv
// ras_predictor_if
//   Bundles the BTB-side fetch-group inputs, the misprediction recovery
//   request and the RAS prediction/checkpoint outputs.
//   master: fetch/BTB/integer-pipeline side (drives fetch + recover inputs)
//   slave : ras_predictor (drives rasOut/rasHit/rasLane/ckptPtr/ckptCount)
interface ras_predictor_if;
    import ras_predictor_pkg::*;

    logic                   fetchValid;
    logic                   stall;
    logic [FETCH_WIDTH-1:0] laneValid;
    PC_Path                 fetchPC [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0] btbHit;
    logic [FETCH_WIDTH-1:0] readIsRASPushBr;
    logic [FETCH_WIDTH-1:0] readIsRASPopBr;

    logic                   recover;
    RasPointerPath          recoverPtr;
    RasCountPath            recoverCount;
    logic                   recoverPush;
    logic                   recoverPop;
    PC_Path                 recoverPushAddr;

    PC_Path                 rasOut;
    logic                   rasHit;
    FetchLaneIndexPath      rasLane;
    RasPointerPath          ckptPtr;
    RasCountPath            ckptCount;

    modport master (
        output fetchValid, stall, laneValid, fetchPC, btbHit,
               readIsRASPushBr, readIsRASPopBr,
               recover, recoverPtr, recoverCount, recoverPush, recoverPop,
               recoverPushAddr,
        input  rasOut, rasHit, rasLane, ckptPtr, ckptCount
    );

    modport slave (
        input  fetchValid, stall, laneValid, fetchPC, btbHit,
               readIsRASPushBr, readIsRASPopBr,
               recover, recoverPtr, recoverCount, recoverPush, recoverPop,
               recoverPushAddr,
        output rasOut, rasHit, rasLane, ckptPtr, ckptCount
    );

endinterface

// File: rtl/ras_entry_array.sv
// ras_entry_array
//   RAS_DEPTH x PC_WIDTH register array, one synchronous write port and one
//   asynchronous read port. Entries are not reset; occupancy tracking in the
//   parent decides which entries are meaningful.
//   clk     : clock
//   wr_en   : write enable
//   wr_addr : write index
//   wr_data : return address to store
//   rd_addr : read index
//   rd_data : entry at rd_addr (combinational)
module ras_entry_array
    import ras_predictor_pkg::*;
(
    input  logic          clk,
    input  logic          wr_en,
    input  RasPointerPath wr_addr,
    input  PC_Path        wr_data,
    input  RasPointerPath rd_addr,
    output PC_Path        rd_data
);

    PC_Path entry_r [RAS_DEPTH];

    // Write port: a value written this cycle is readable next cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            entry_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = entry_r[rd_addr];

endmodule

// File: rtl/ras_predictor.sv
// ras_predictor
//   Return address stack downstream of the BTB. Selects the first lane of
//   the fetch group carrying a BTB-classified call/return, pushes return
//   addresses on calls, predicts targets on returns, exposes the pre-update
//   pointer/occupancy as a checkpoint and restores it on misprediction.
//   clk  : clock
//   rst  : synchronous active-high reset (ptr=0, count=0; entries kept)
//   bus  : ras_predictor_if.slave (fetch group, recovery, prediction outputs)
module ras_predictor
    import ras_predictor_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    ras_predictor_if.slave  bus
);

    RasPointerPath     ptr_r;
    RasCountPath       count_r;
    RasPointerPath     ptr_nxt_s;
    RasCountPath       count_nxt_s;

    logic              wr_en_s;
    RasPointerPath     wr_addr_s;
    PC_Path            wr_data_s;
    PC_Path            rd_data_s;

    logic              sel_valid_s;
    FetchLaneIndexPath sel_lane_s;
    logic              sel_push_s;
    logic              sel_pop_s;
    PC_Path            sel_ret_addr_s;
    logic              update_s;
    RasCheckpoint      ckpt_s;

    ras_entry_array u_entries (
        .clk     (clk),
        .wr_en   (wr_en_s && !rst),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data_s),
        .rd_addr (ptr_r),
        .rd_data (rd_data_s)
    );

    // Lane scan: lowest-index lane with a BTB-hit call or return wins; the
    // group ends at that taken branch so later lanes are ignored.
    always_comb begin
        sel_valid_s    = 1'b0;
        sel_lane_s     = {FETCH_LANE_BIT_WIDTH{1'b0}};
        sel_push_s     = 1'b0;
        sel_pop_s      = 1'b0;
        sel_ret_addr_s = bus.fetchPC[0] + PC_Path'(INSN_BYTE_WIDTH);
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (!sel_valid_s && bus.fetchValid && bus.laneValid[i] && bus.btbHit[i] &&
                (bus.readIsRASPushBr[i] || bus.readIsRASPopBr[i])) begin
                sel_valid_s    = 1'b1;
                sel_lane_s     = FetchLaneIndexPath'(i);
                sel_push_s     = bus.readIsRASPushBr[i];
                sel_pop_s      = bus.readIsRASPopBr[i];
                sel_ret_addr_s = bus.fetchPC[i] + PC_Path'(INSN_BYTE_WIDTH);
            end else begin
                sel_valid_s    = sel_valid_s;
            end
        end
    end

    assign update_s = bus.fetchValid && !bus.stall && !bus.recover;
    assign ckpt_s   = '{ptr: ptr_r, count: count_r};

    // Prediction and checkpoint outputs are combinational from current state.
    assign bus.rasOut    = rd_data_s;
    assign bus.rasHit    = sel_valid_s && sel_pop_s && (count_r != RAS_COUNT_ZERO);
    assign bus.rasLane   = sel_lane_s;
    assign bus.ckptPtr   = ckpt_s.ptr;
    assign bus.ckptCount = ckpt_s.count;

    // Next pointer/occupancy and entry write; recovery outranks fetch updates.
    always_comb begin
        ptr_nxt_s   = ptr_r;
        count_nxt_s = count_r;
        wr_en_s     = 1'b0;
        wr_addr_s   = ptr_r + RAS_PTR_ONE;
        wr_data_s   = sel_ret_addr_s;
        if (bus.recover) begin
            ptr_nxt_s   = bus.recoverPtr;
            count_nxt_s = bus.recoverCount;
            wr_data_s   = bus.recoverPushAddr;
            if (bus.recoverPush && bus.recoverPop) begin
                // Replayed call-via-return: replace the checkpointed top.
                wr_en_s     = 1'b1;
                wr_addr_s   = bus.recoverPtr;
                count_nxt_s = ras_count_floor1(bus.recoverCount);
            end else if (bus.recoverPush) begin
                wr_en_s     = 1'b1;
                wr_addr_s   = bus.recoverPtr + RAS_PTR_ONE;
                ptr_nxt_s   = bus.recoverPtr + RAS_PTR_ONE;
                count_nxt_s = ras_count_inc(bus.recoverCount);
            end else if (bus.recoverPop) begin
                ptr_nxt_s   = bus.recoverPtr - RAS_PTR_ONE;
                count_nxt_s = ras_count_dec(bus.recoverCount);
            end else begin
                wr_en_s     = 1'b0;
            end
        end else if (update_s && sel_valid_s) begin
            if (sel_push_s && sel_pop_s) begin
                wr_en_s     = 1'b1;
                wr_addr_s   = ptr_r;
                count_nxt_s = ras_count_floor1(count_r);
            end else if (sel_push_s) begin
                // When full this lands on the oldest entry, overwriting it.
                wr_en_s     = 1'b1;
                ptr_nxt_s   = ptr_r + RAS_PTR_ONE;
                count_nxt_s = ras_count_inc(count_r);
            end else if (count_r != RAS_COUNT_ZERO) begin
                ptr_nxt_s   = ptr_r - RAS_PTR_ONE;
                count_nxt_s = count_r - RAS_COUNT_ONE;
            end else begin
                // Pop on an empty stack leaves state untouched.
                ptr_nxt_s   = ptr_r;
            end
        end else begin
            ptr_nxt_s   = ptr_r;
        end
    end

    // Pointer/occupancy registers; reset overrides recovery and fetch updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r   <= RAS_PTR_ZERO;
            count_r <= RAS_COUNT_ZERO;
        end else begin
            ptr_r   <= ptr_nxt_s;
            count_r <= count_nxt_s;
        end
    end

endmodule

// File: tb/tb_ras_predictor.sv
// tb_ras_predictor
//   Directed vectors drive the RAS one cycle each; the expected response for
//   every vector is queued by the driver and a separate negedge monitor pops
//   and compares it against the DUT outputs.
module tb_ras_predictor;
    import ras_predictor_pkg::*;

    logic clk;
    logic rst;

    ras_predictor_if bus ();

    ras_predictor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fv;
        logic        stall;
        logic [1:0]  lv;
        logic [1:0]  hit;
        logic [1:0]  push;
        logic [1:0]  pop;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic        rec;
        logic [2:0]  rptr;
        logic [3:0]  rcnt;
        logic        rpush;
        logic        rpop;
        logic [31:0] raddr;
    } vec_t;

    typedef struct {
        string       name;
        logic        hit;
        logic [31:0] out;
        logic        lane;
        logic [2:0]  ptr;
        logic [3:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   applied = 0;
    int   miscompares = 0;

    function automatic vec_t v_idle();
        vec_t v;
        v.rst = 1'b0; v.fv = 1'b0; v.stall = 1'b0;
        v.lv = 2'b00; v.hit = 2'b00; v.push = 2'b00; v.pop = 2'b00;
        v.pc0 = 32'h0; v.pc1 = 32'h4;
        v.rec = 1'b0; v.rptr = 3'd0; v.rcnt = 4'd0;
        v.rpush = 1'b0; v.rpop = 1'b0; v.raddr = 32'h0;
        return v;
    endfunction

    function automatic vec_t v_grp(input logic [31:0] grp_pc);
        vec_t v;
        v = v_idle();
        v.fv = 1'b1; v.lv = 2'b11;
        v.pc0 = grp_pc; v.pc1 = grp_pc + 32'd4;
        return v;
    endfunction

    function automatic exp_t mk_exp(input string nm, input logic h, input logic [31:0] o,
                                    input logic l, input logic [2:0] p, input logic [3:0] c);
        exp_t e;
        e.name = nm; e.hit = h; e.out = o; e.lane = l; e.ptr = p; e.cnt = c;
        return e;
    endfunction

    task automatic apply(input vec_t v, input exp_t e);
        @(posedge clk);
        #1;
        rst                 = v.rst;
        bus.fetchValid      = v.fv;
        bus.stall           = v.stall;
        bus.laneValid       = v.lv;
        bus.btbHit          = v.hit;
        bus.readIsRASPushBr = v.push;
        bus.readIsRASPopBr  = v.pop;
        bus.fetchPC[0]      = v.pc0;
        bus.fetchPC[1]      = v.pc1;
        bus.recover         = v.rec;
        bus.recoverPtr      = v.rptr;
        bus.recoverCount    = v.rcnt;
        bus.recoverPush     = v.rpush;
        bus.recoverPop      = v.rpop;
        bus.recoverPushAddr = v.raddr;
        exp_q.push_back(e);
    endtask

    task automatic do_idle(input string nm, input logic [2:0] p, input logic [3:0] c);
        apply(v_idle(), mk_exp(nm, 1'b0, 32'h0, 1'b0, p, c));
    endtask

    task automatic do_push(input string nm, input int lane, input logic [31:0] grp_pc,
                           input logic [2:0] p, input logic [3:0] c);
        vec_t v;
        v = v_grp(grp_pc);
        v.hit[lane] = 1'b1; v.push[lane] = 1'b1;
        apply(v, mk_exp(nm, 1'b0, 32'h0, lane[0], p, c));
    endtask

    task automatic do_pop(input string nm, input int lane, input logic stl, input logic eh,
                          input logic [31:0] eo, input logic [2:0] p, input logic [3:0] c);
        vec_t v;
        v = v_grp(32'h0000_7000);
        v.stall = stl;
        v.hit[lane] = 1'b1; v.pop[lane] = 1'b1;
        apply(v, mk_exp(nm, eh, eo, lane[0], p, c));
    endtask

    task automatic check(input string nm, input string fld, input logic [31:0] act,
                         input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, req);
        end
    endtask

    // Monitor: one queued expectation per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            applied++;
            check(mon_e.name, "rasHit",    {31'd0, bus.rasHit},    {31'd0, mon_e.hit});
            check(mon_e.name, "rasLane",   {31'd0, bus.rasLane},   {31'd0, mon_e.lane});
            check(mon_e.name, "ckptPtr",   {29'd0, bus.ckptPtr},   {29'd0, mon_e.ptr});
            check(mon_e.name, "ckptCount", {28'd0, bus.ckptCount}, {28'd0, mon_e.cnt});
            if (mon_e.hit) begin
                check(mon_e.name, "rasOut", bus.rasOut, mon_e.out);
            end
        end
    end

    initial begin
        vec_t v;
        rst = 1'b1;
        v = v_idle();
        bus.fetchValid = 1'b0; bus.stall = 1'b0; bus.laneValid = 2'b00;
        bus.btbHit = 2'b00; bus.readIsRASPushBr = 2'b00; bus.readIsRASPopBr = 2'b00;
        bus.fetchPC[0] = 32'h0; bus.fetchPC[1] = 32'h0;
        bus.recover = 1'b0; bus.recoverPtr = 3'd0; bus.recoverCount = 4'd0;
        bus.recoverPush = 1'b0; bus.recoverPop = 1'b0; bus.recoverPushAddr = 32'h0;
        repeat (3) @(posedge clk);

        // Reset state and pop on empty stack
        do_idle("reset", 3'd0, 4'd0);
        do_pop("pop_empty", 0, 1'b0, 1'b0, 32'h0, 3'd0, 4'd0);
        do_idle("after_pop_empty", 3'd0, 4'd0);

        // Push lane 1 of group 0x1000 (lane PC 0x1004), pop next cycle on lane 0
        do_push("push_l1", 1, 32'h0000_1000, 3'd0, 4'd0);
        do_pop("pop_l0", 0, 1'b0, 1'b1, 32'h0000_1008, 3'd1, 4'd1);
        do_idle("count_back_0", 3'd0, 4'd0);

        // Nine pushes overflow the eight-entry stack, then nine pops
        for (int k = 1; k <= 9; k++) begin
            do_push($sformatf("ovf_push%0d", k), 0, 32'h100 * k,
                    3'((k - 1) % 8), 4'((k - 1 > 8) ? 8 : k - 1));
        end
        do_idle("full", 3'd1, 4'd8);
        for (int j = 1; j <= 8; j++) begin
            do_pop($sformatf("lifo_pop%0d", j), 0, 1'b0, 1'b1, 32'h100 * (10 - j) + 32'h4,
                   3'((1 - (j - 1)) & 7), 4'(8 - (j - 1)));
        end
        do_pop("lifo_pop9", 0, 1'b0, 1'b0, 32'h0, 3'd1, 4'd0);
        do_idle("drained", 3'd1, 4'd0);

        // Lane 0 push wins over lane 1 pop in the same group
        v = v_grp(32'h0000_5000);
        v.hit = 2'b11; v.push = 2'b01; v.pop = 2'b10;
        apply(v, mk_exp("scan_push_first", 1'b0, 32'h0, 1'b0, 3'd1, 4'd0));
        v = v_grp(32'h0000_7000);
        v.hit = 2'b10; v.pop = 2'b10;
        apply(v, mk_exp("pop_lane1", 1'b1, 32'h0000_5004, 1'b1, 3'd2, 4'd1));

        // Reset mid-operation overrides a simultaneous recover push
        v = v_idle();
        v.rst = 1'b1; v.rec = 1'b1; v.rptr = 3'd4; v.rcnt = 4'd4; v.rpush = 1'b1;
        v.raddr = 32'hDEAD_0000;
        apply(v, mk_exp("rst_mid", 1'b0, 32'h0, 1'b0, 3'd1, 4'd0));
        do_idle("after_rst", 3'd0, 4'd0);

        // Checkpoint recovery: pop replay with a concurrent fetch push ignored
        do_push("prime_1004", 0, 32'h0000_1000, 3'd0, 4'd0);
        do_push("push_2004", 0, 32'h0000_2000, 3'd1, 4'd1);
        do_push("push_3004", 0, 32'h0000_3000, 3'd2, 4'd2);
        v = v_grp(32'h0000_7000);
        v.hit = 2'b01; v.push = 2'b01;
        v.rec = 1'b1; v.rptr = 3'd2; v.rcnt = 4'd2; v.rpop = 1'b1;
        apply(v, mk_exp("recover_pop", 1'b0, 32'h0, 1'b0, 3'd3, 4'd3));
        do_pop("pop_after_rec", 0, 1'b0, 1'b1, 32'h0000_1004, 3'd1, 4'd1);

        // Recovery with push replay
        v = v_idle();
        v.rec = 1'b1; v.rptr = 3'd0; v.rcnt = 4'd0; v.rpush = 1'b1; v.raddr = 32'h0000_ABC0;
        apply(v, mk_exp("recover_push", 1'b0, 32'h0, 1'b0, 3'd0, 4'd0));
        do_pop("pop_rec_push", 0, 1'b0, 1'b1, 32'h0000_ABC0, 3'd1, 4'd1);

        // Recovery with push-and-pop replay replaces the top
        do_push("push_4004", 0, 32'h0000_4000, 3'd0, 4'd0);
        v = v_idle();
        v.rec = 1'b1; v.rptr = 3'd1; v.rcnt = 4'd0; v.rpush = 1'b1; v.rpop = 1'b1;
        v.raddr = 32'h0000_BEE0;
        apply(v, mk_exp("recover_pushpop", 1'b0, 32'h0, 1'b0, 3'd1, 4'd1));
        do_pop("pop_rec_pp", 0, 1'b0, 1'b1, 32'h0000_BEE0, 3'd1, 4'd1);

        // Fetch push-and-pop on one lane, non-empty then empty stack
        do_push("push_6004", 0, 32'h0000_6000, 3'd0, 4'd0);
        v = v_grp(32'h0000_6100);
        v.hit = 2'b01; v.push = 2'b01; v.pop = 2'b01;
        apply(v, mk_exp("pushpop_full", 1'b1, 32'h0000_6004, 1'b0, 3'd1, 4'd1));
        do_pop("pop_6104", 0, 1'b0, 1'b1, 32'h0000_6104, 3'd1, 4'd1);
        v = v_grp(32'h0000_6200);
        v.hit = 2'b01; v.push = 2'b01; v.pop = 2'b01;
        apply(v, mk_exp("pushpop_empty", 1'b0, 32'h0, 1'b0, 3'd0, 4'd0));
        do_pop("pop_6204", 0, 1'b0, 1'b1, 32'h0000_6204, 3'd0, 4'd1);
        do_idle("wrap_ptr7", 3'd7, 4'd0);

        // Stall holds state while still presenting the prediction
        do_push("push_8004", 0, 32'h0000_8000, 3'd7, 4'd0);
        do_pop("pop_stalled", 0, 1'b1, 1'b1, 32'h0000_8004, 3'd0, 4'd1);
        do_pop("pop_unstalled", 0, 1'b0, 1'b1, 32'h0000_8004, 3'd0, 4'd1);
        do_idle("after_stall", 3'd7, 4'd0);

        // Pop replay from an empty checkpoint clamps occupancy at zero
        v = v_idle();
        v.rec = 1'b1; v.rptr = 3'd7; v.rcnt = 4'd0; v.rpop = 1'b1;
        apply(v, mk_exp("recover_pop_empty", 1'b0, 32'h0, 1'b0, 3'd7, 4'd0));
        do_idle("clamped", 3'd6, 4'd0);

        @(posedge clk);
        #1;
        bus.fetchValid = 1'b0; bus.recover = 1'b0;
        for (int k = 0; k < 8 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
